// File: rtl/sync_fifo_ctrl_if.sv
// Handshake bundle for sync_fifo_ctrl: write side, read side, flush and status.
// The master modport is the side that produces requests; the slave is the FIFO itself.
interface sync_fifo_ctrl_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             flush;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             walmost_full;
  logic             overflow;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             ralmost_empty;
  logic             underflow;
  logic [ASIZE:0]   count;

  modport master (
    output flush, winc, wdata, rinc,
    input  wfull, walmost_full, overflow, rdata, rempty, ralmost_empty, underflow, count
  );

  modport slave (
    input  flush, winc, wdata, rinc,
    output wfull, walmost_full, overflow, rdata, rempty, ralmost_empty, underflow, count
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill level, almost-full/empty flags, sticky error flags and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_ctrl #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_ctrl_if.slave fifo
);

  localparam int             DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] ONE   = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] AF_C  = (ASIZE+1)'(AF_THRESH);
  localparam logic [ASIZE:0] AE_C  = (ASIZE+1)'(AE_THRESH);

  if (!(AE_THRESH >= 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_param_check
    $error("sync_fifo_ctrl: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wptr_q,  wptr_d;
  logic [ASIZE:0] rptr_q,  rptr_d;
  logic [ASIZE:0] count_q, count_d;
  logic           wfull_q, wfull_d;
  logic           rempty_q, rempty_d;
  logic           af_q, af_d;
  logic           ae_q, ae_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;
  logic           wr_en, rd_en;

  // Flush outranks both requests, so neither the memory nor the flags see them.
  assign wr_en = fifo.winc && !wfull_q  && !fifo.flush;
  assign rd_en = fifo.rinc && !rempty_q && !fifo.flush;

  // NOTE: every signal gets its default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (fifo.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + ONE;
      if (rd_en) rptr_d = rptr_q + ONE;
      if (wr_en && !rd_en)      count_d = count_q + ONE;
      else if (rd_en && !wr_en) count_d = count_q - ONE;
      ovf_d = ovf_q || (fifo.winc && wfull_q);
      udf_d = udf_q || (fifo.rinc && rempty_q);
    end

    // Flags are computed from next state so they are registered yet current after the edge.
    wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
               (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
    rempty_d = (wptr_d == rptr_d);
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[ASIZE-1:0]] <= fifo.wdata;
  end

`ifdef FIFO_FWFT_EN
  // Head of queue is always on the output; rinc simply advances past it.
  assign fifo.rdata = mem[rptr_q[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[rptr_q[ASIZE-1:0]];
  end

  assign fifo.rdata = rdata_q;
`endif

  assign fifo.wfull         = wfull_q;
  assign fifo.walmost_full  = af_q;
  assign fifo.overflow      = ovf_q;
  assign fifo.rempty        = rempty_q;
  assign fifo.ralmost_empty = ae_q;
  assign fifo.underflow     = udf_q;
  assign fifo.count         = count_q;

endmodule
